// File: rtl/axis_out_packer_pkg.sv
// Shared constants and helpers for the AXI-Stream output packer.
// Optional statistics counters are enabled by defining OUT_PACKER_STATS_EN.
package axis_out_packer_pkg;

   localparam int STATS_W  = 32;
   localparam int KEEP_MAX = 64;

   // Width needed to hold a word count in the range 0..buf_words.
   function automatic int count_width(input int buf_words);
      return $clog2(buf_words + 1);
   endfunction

   function automatic int popcount(input logic [KEEP_MAX-1:0] keep);
      int c;
      c = 0;
      for (int i = 0; i < KEEP_MAX; i++)
         if (keep[i]) c++;
      return c;
   endfunction

endpackage

// File: rtl/axis_out_packer_if.sv
// AXI-Stream bundle shared by the packer input and output sides.
interface axis_out_packer_if #(
   parameter int WORDS      = 8,
   parameter int WORD_WIDTH = 32,
   parameter int USER_WIDTH = 8
);
   logic                        tvalid;
   logic                        tready;
   logic                        tlast;
   logic [WORDS*WORD_WIDTH-1:0] tdata;
   logic [WORDS-1:0]            tkeep;
   logic [USER_WIDTH-1:0]       tuser;

   modport master (output tvalid, tlast, tdata, tkeep, tuser, input tready);
   modport slave  (input tvalid, tlast, tdata, tkeep, tuser, output tready);
endinterface

// File: rtl/axis_out_packer.sv
// Repacks S_WORDS-wide input beats into M_WORDS-wide output beats, dropping config beats.
// Define OUT_PACKER_STATS_EN to add the stat_frames / stat_cfg_drops counters.
module axis_out_packer
   import axis_out_packer_pkg::*;
#(
   parameter int WORD_WIDTH  = 32,
   parameter int S_WORDS     = 8,
   parameter int M_WORDS     = 4,
   parameter int USER_WIDTH  = 8,
   parameter int I_IS_CONFIG = 0
) (
   input logic               aclk,
   input logic               aresetn,
   axis_out_packer_if.slave  s_axis,
   axis_out_packer_if.master m_axis
`ifdef OUT_PACKER_STATS_EN
   ,
   output logic [STATS_W-1:0] stat_frames,
   output logic [STATS_W-1:0] stat_cfg_drops
`endif
);

   localparam int BUF_WORDS = S_WORDS + M_WORDS;
   localparam int COUNT_W   = count_width(BUF_WORDS);

   typedef logic [WORD_WIDTH-1:0] word_t;

   word_t               buf_q [BUF_WORDS];
   word_t               buf_d [BUF_WORDS];
   logic [COUNT_W-1:0]  count_q, count_d;
   logic                last_pending_q, last_pending_d;

   logic                        in_ready, out_valid, out_last;
   logic [M_WORDS*WORD_WIDTH-1:0] out_data;
   logic [M_WORDS-1:0]          out_keep;
   logic                        s_hs, m_hs, cfg_beat, data_beat;
   int                          k_out, n_in, kp, base;

   // Ready depends only on state, so there is no path from m_axis.tready.
   assign in_ready  = aresetn && !last_pending_q && (int'(count_q) <= M_WORDS);
   assign out_valid = (int'(count_q) >= M_WORDS) || (last_pending_q && count_q != '0);
   assign out_last  = last_pending_q && (int'(count_q) <= M_WORDS);

   assign s_hs      = s_axis.tvalid && in_ready;
   assign m_hs      = out_valid && m_axis.tready;
   assign cfg_beat  = s_hs && s_axis.tuser[I_IS_CONFIG];
   assign data_beat = s_hs && !s_axis.tuser[I_IS_CONFIG];

   assign s_axis.tready = in_ready;
   assign m_axis.tvalid = out_valid;
   assign m_axis.tlast  = out_last;
   assign m_axis.tdata  = out_data;
   assign m_axis.tkeep  = out_keep;
   assign m_axis.tuser  = '0;

   // Oldest k words go out; unused lanes are forced to zero.
   always_comb begin
      k_out    = (int'(count_q) >= M_WORDS) ? M_WORDS : int'(count_q);
      out_data = '0;
      out_keep = '0;
      for (int i = 0; i < M_WORDS; i++) begin
         if (i < k_out) begin
            out_data[i*WORD_WIDTH +: WORD_WIDTH] = buf_q[i];
            out_keep[i] = 1'b1;
         end
      end
   end

   always_comb begin
      n_in = popcount(KEEP_MAX'(s_axis.tkeep));
      kp   = m_hs ? k_out : 0;
      base = int'(count_q) - kp;
      for (int i = 0; i < BUF_WORDS; i++) begin
         buf_d[i] = '0;
         for (int k = 0; k <= M_WORDS && i + k < BUF_WORDS; k++)
            if (kp == k) buf_d[i] = buf_q[i+k];
         // Incoming words land right after the survivors of this cycle's pop.
         for (int j = 0; j < S_WORDS; j++)
            if (data_beat && j < n_in && i == base + j)
               buf_d[i] = s_axis.tdata[j*WORD_WIDTH +: WORD_WIDTH];
      end
      count_d = COUNT_W'(base + (data_beat ? n_in : 0));

      last_pending_d = last_pending_q;
      if (data_beat && s_axis.tlast) last_pending_d = 1'b1;
      if (m_hs && out_last)          last_pending_d = 1'b0;
      if (last_pending_q && count_q == '0) last_pending_d = 1'b0;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         count_q        <= '0;
         last_pending_q <= 1'b0;
      end else begin
         count_q        <= count_d;
         last_pending_q <= last_pending_d;
      end
   end

   // Word storage needs no reset: count gates everything that reaches the output.
   always_ff @(posedge aclk) begin
      for (int i = 0; i < BUF_WORDS; i++) buf_q[i] <= buf_d[i];
   end

`ifdef OUT_PACKER_STATS_EN
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         stat_frames    <= '0;
         stat_cfg_drops <= '0;
      end else begin
         if (m_hs && out_last) stat_frames    <= stat_frames + 1'b1;
         if (cfg_beat)         stat_cfg_drops <= stat_cfg_drops + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_axis_out_packer.sv
// Scoreboard bench for axis_out_packer: three instances (8:4, 4:8, 4:4 word ratios).
module tb_axis_out_packer;

   typedef struct {
      logic [255:0] d;
      logic [7:0]   k;
      logic         l;
   } beat_t;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic         s_tvalid [3];
   logic         s_tlast  [3];
   logic [255:0] s_tdata  [3];
   logic [7:0]   s_tkeep  [3];
   logic [7:0]   s_tuser  [3];
   logic         m_tready [3];
   logic         s_rdy    [3];
   logic         m_vld    [3];
   logic         m_lst    [3];
   logic [255:0] m_dat    [3];
   logic [7:0]   m_kp     [3];
   beat_t        exp_q    [3][$];
   logic [31:0]  frames   [3];
   logic [31:0]  drops    [3];

   axis_out_packer_if #(.WORDS(8), .WORD_WIDTH(32), .USER_WIDTH(8)) s0_if ();
   axis_out_packer_if #(.WORDS(4), .WORD_WIDTH(32), .USER_WIDTH(8)) m0_if ();
   axis_out_packer_if #(.WORDS(4), .WORD_WIDTH(32), .USER_WIDTH(8)) s1_if ();
   axis_out_packer_if #(.WORDS(8), .WORD_WIDTH(32), .USER_WIDTH(8)) m1_if ();
   axis_out_packer_if #(.WORDS(4), .WORD_WIDTH(32), .USER_WIDTH(8)) s2_if ();
   axis_out_packer_if #(.WORDS(4), .WORD_WIDTH(32), .USER_WIDTH(8)) m2_if ();

   assign s0_if.tvalid = s_tvalid[0];  assign s0_if.tlast = s_tlast[0];
   assign s0_if.tdata  = s_tdata[0];   assign s0_if.tkeep = s_tkeep[0];
   assign s0_if.tuser  = s_tuser[0];   assign s_rdy[0]    = s0_if.tready;
   assign s1_if.tvalid = s_tvalid[1];  assign s1_if.tlast = s_tlast[1];
   assign s1_if.tdata  = s_tdata[1][127:0]; assign s1_if.tkeep = s_tkeep[1][3:0];
   assign s1_if.tuser  = s_tuser[1];   assign s_rdy[1]    = s1_if.tready;
   assign s2_if.tvalid = s_tvalid[2];  assign s2_if.tlast = s_tlast[2];
   assign s2_if.tdata  = s_tdata[2][127:0]; assign s2_if.tkeep = s_tkeep[2][3:0];
   assign s2_if.tuser  = s_tuser[2];   assign s_rdy[2]    = s2_if.tready;

   assign m0_if.tready = m_tready[0];  assign m_vld[0] = m0_if.tvalid;  assign m_lst[0] = m0_if.tlast;
   assign m_dat[0] = {128'b0, m0_if.tdata};  assign m_kp[0] = {4'b0, m0_if.tkeep};
   assign m1_if.tready = m_tready[1];  assign m_vld[1] = m1_if.tvalid;  assign m_lst[1] = m1_if.tlast;
   assign m_dat[1] = m1_if.tdata;             assign m_kp[1] = m1_if.tkeep;
   assign m2_if.tready = m_tready[2];  assign m_vld[2] = m2_if.tvalid;  assign m_lst[2] = m2_if.tlast;
   assign m_dat[2] = {128'b0, m2_if.tdata};  assign m_kp[2] = {4'b0, m2_if.tkeep};

   axis_out_packer #(.WORD_WIDTH(32), .S_WORDS(8), .M_WORDS(4), .USER_WIDTH(8), .I_IS_CONFIG(0)) u0 (
      .aclk(aclk), .aresetn(aresetn), .s_axis(s0_if), .m_axis(m0_if)
`ifdef OUT_PACKER_STATS_EN
      , .stat_frames(frames[0]), .stat_cfg_drops(drops[0])
`endif
   );
   axis_out_packer #(.WORD_WIDTH(32), .S_WORDS(4), .M_WORDS(8), .USER_WIDTH(8), .I_IS_CONFIG(0)) u1 (
      .aclk(aclk), .aresetn(aresetn), .s_axis(s1_if), .m_axis(m1_if)
`ifdef OUT_PACKER_STATS_EN
      , .stat_frames(frames[1]), .stat_cfg_drops(drops[1])
`endif
   );
   axis_out_packer #(.WORD_WIDTH(32), .S_WORDS(4), .M_WORDS(4), .USER_WIDTH(8), .I_IS_CONFIG(0)) u2 (
      .aclk(aclk), .aresetn(aresetn), .s_axis(s2_if), .m_axis(m2_if)
`ifdef OUT_PACKER_STATS_EN
      , .stat_frames(frames[2]), .stat_cfg_drops(drops[2])
`endif
   );

   initial forever begin
      @(posedge aclk);
      cyc++;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end

   // Output monitor: pops the scoreboard on every handshake and checks stall stability.
   initial begin
      logic  stall_q [3];
      beat_t held    [3];
      beat_t e;
      for (int u = 0; u < 3; u++) stall_q[u] = 1'b0;
      forever begin
         @(negedge aclk);
         for (int u = 0; u < 3; u++) begin
            if (!aresetn) begin
               stall_q[u] = 1'b0;
            end else begin
               if (stall_q[u]) begin
                  total++;
                  if (m_vld[u] !== 1'b1 || m_dat[u] !== held[u].d || m_kp[u] !== held[u].k || m_lst[u] !== held[u].l) begin
                     bad++;
                     $display("FAIL stall_stable u%0d: got v=%b k=%h l=%b d=%h, want v=1 k=%h l=%b d=%h",
                              u, m_vld[u], m_kp[u], m_lst[u], m_dat[u], held[u].k, held[u].l, held[u].d);
                  end
               end
               if (m_vld[u] === 1'b1 && m_tready[u] === 1'b1) begin
                  total++;
                  if (exp_q[u].size() == 0) begin
                     bad++;
                     $display("FAIL unexpected_beat u%0d: got k=%h l=%b d=%h, want no beat", u, m_kp[u], m_lst[u], m_dat[u]);
                  end else begin
                     e = exp_q[u].pop_front();
                     if (m_dat[u] !== e.d || m_kp[u] !== e.k || m_lst[u] !== e.l) begin
                        bad++;
                        $display("FAIL out_beat u%0d: got k=%h l=%b d=%h, want k=%h l=%b d=%h",
                                 u, m_kp[u], m_lst[u], m_dat[u], e.k, e.l, e.d);
                     end
                  end
               end
               stall_q[u] = (m_vld[u] === 1'b1) && (m_tready[u] !== 1'b1);
               held[u].d = m_dat[u];
               held[u].k = m_kp[u];
               held[u].l = m_lst[u];
            end
         end
      end
   end

   function automatic int mw(input int u);
      return (u == 1) ? 8 : 4;
   endfunction

   function automatic logic [255:0] pack(input logic [31:0] base, input int nw);
      logic [255:0] d;
      d = '0;
      for (int i = 0; i < nw; i++) d[i*32 +: 32] = base + 32'(i);
      return d;
   endfunction

   // Reference: a frame's words split into M-word chunks, last chunk partial with tlast.
   task automatic exp_frame(input int u, input logic [31:0] w[$]);
      beat_t b;
      int    i;
      i = 0;
      while (i < w.size()) begin
         b.d = '0;
         b.k = '0;
         for (int j = 0; j < mw(u) && i < w.size(); j++) begin
            b.d[j*32 +: 32] = w[i];
            b.k[j] = 1'b1;
            i++;
         end
         b.l = (i == w.size());
         exp_q[u].push_back(b);
      end
   endtask

   task automatic exp_words(input int u, input logic [31:0] base, input int nw);
      logic [31:0] w[$];
      for (int i = 0; i < nw; i++) w.push_back(base + 32'(i));
      exp_frame(u, w);
   endtask

   task automatic send(input int u, input logic [255:0] d, input logic [7:0] k, input logic l, input logic cfg);
      int n;
      n = 0;
      s_tvalid[u] = 1'b1;
      s_tdata[u]  = d;
      s_tkeep[u]  = k;
      s_tlast[u]  = l;
      s_tuser[u]  = {7'b0, cfg};
      @(negedge aclk);
      while (s_rdy[u] !== 1'b1 && n < 500) begin
         n++;
         @(negedge aclk);
      end
      if (n >= 500) begin
         total++;
         bad++;
         $display("FAIL send_timeout u%0d: not accepted after %0d cycles, want accept", u, n);
      end
      @(posedge aclk);
      #1;
      s_tvalid[u] = 1'b0;
      s_tlast[u]  = 1'b0;
      s_tuser[u]  = '0;
   endtask

   task automatic wait_drain(input int u);
      int n;
      n = 0;
      while (exp_q[u].size() != 0 && n < 3000) begin
         @(posedge aclk);
         n++;
      end
      total++;
      if (exp_q[u].size() != 0) begin
         bad++;
         $display("FAIL drain u%0d: %0d beats still expected, want 0", u, exp_q[u].size());
      end
      @(negedge aclk);
      total++;
      if (m_vld[u] !== 1'b0) begin
         bad++;
         $display("FAIL idle_after_drain u%0d: tvalid=%b, want 0", u, m_vld[u]);
      end
      @(posedge aclk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      for (int u = 0; u < 3; u++) begin
         total++;
         if (s_rdy[u] !== 1'b0 || m_vld[u] !== 1'b0 || m_lst[u] !== 1'b0 || m_dat[u] !== '0 || m_kp[u] !== '0) begin
            bad++;
            $display("FAIL reset_outputs u%0d: got rdy=%b v=%b l=%b k=%h d=%h, want all 0", u, s_rdy[u], m_vld[u], m_lst[u], m_kp[u], m_dat[u]);
         end
      end
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(negedge aclk);
      for (int u = 0; u < 3; u++) begin
         total++;
         if (s_rdy[u] !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset u%0d: got %b, want 1", u, s_rdy[u]);
         end
      end
`ifdef OUT_PACKER_STATS_EN
      total++;
      if (frames[0] !== 32'd0 || drops[0] !== 32'd0) begin
         bad++;
         $display("FAIL stats_reset: got frames=%0d drops=%0d, want 0 0", frames[0], drops[0]);
      end
`endif
      @(posedge aclk);
      #1;
   endtask

   task automatic test_s8m4();
      exp_words(0, 32'd0, 16);
      send(0, pack(32'd0, 8), 8'hFF, 1'b0, 1'b0);
      send(0, pack(32'd8, 8), 8'hFF, 1'b1, 1'b0);
      wait_drain(0);
   endtask

   task automatic test_s4m8();
      exp_words(1, 32'd0, 12);
      send(1, pack(32'd0, 4), 8'h0F, 1'b0, 1'b0);
      send(1, pack(32'd4, 4), 8'h0F, 1'b0, 1'b0);
      send(1, pack(32'd8, 4), 8'h0F, 1'b1, 1'b0);
      wait_drain(1);
   endtask

   task automatic test_partial_keep();
      exp_words(0, 32'h20, 3);
      send(0, pack(32'h20, 8), 8'h07, 1'b1, 1'b0);
      wait_drain(0);
   endtask

   task automatic test_config();
      exp_words(0, 32'h100, 16);
      send(0, pack(32'h100, 8), 8'hFF, 1'b0, 1'b0);
      send(0, pack(32'hDEAD0000, 8), 8'hFF, 1'b1, 1'b1);
      send(0, pack(32'h108, 8), 8'hFF, 1'b1, 1'b0);
      wait_drain(0);
`ifdef OUT_PACKER_STATS_EN
      total++;
      if (drops[0] !== 32'd1 || frames[0] !== 32'd3) begin
         bad++;
         $display("FAIL stats_count: got drops=%0d frames=%0d, want 1 3", drops[0], frames[0]);
      end
`endif
   endtask

   task automatic test_empty_frame();
      send(0, pack(32'h55, 8), 8'h00, 1'b1, 1'b0);
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      total++;
      if (m_vld[0] !== 1'b0 || s_rdy[0] !== 1'b1) begin
         bad++;
         $display("FAIL empty_frame: got v=%b rdy=%b, want v=0 rdy=1", m_vld[0], s_rdy[0]);
      end
      @(posedge aclk);
      #1;
      exp_words(0, 32'h40, 2);
      send(0, pack(32'h40, 8), 8'h03, 1'b1, 1'b0);
      wait_drain(0);
   endtask

   task automatic test_random_stall();
      logic [31:0]  w[$];
      logic [7:0]   kq[$];
      logic [255:0] d;
      logic [31:0]  wid;
      int           beats, nb, nk, idx;
      bit           done;
      wid  = 32'h1000;
      done = 1'b0;
      fork
         begin
            beats = 0;
            while (beats < 1000) begin
               nb = $urandom_range(1, 8);
               if (beats + nb > 1000) nb = 1000 - beats;
               w.delete();
               kq.delete();
               for (int b = 0; b < nb; b++) begin
                  nk = $urandom_range(1, 4);
                  kq.push_back(8'((1 << nk) - 1));
                  for (int x = 0; x < nk; x++) begin
                     w.push_back(wid);
                     wid++;
                  end
               end
               exp_frame(2, w);
               idx = 0;
               for (int b = 0; b < nb; b++) begin
                  d = '0;
                  for (int x = 0; x < 4; x++) begin
                     if (kq[b][x]) begin
                        d[x*32 +: 32] = w[idx];
                        idx++;
                     end else begin
                        d[x*32 +: 32] = $urandom;
                     end
                  end
                  send(2, d, kq[b], (b == nb - 1), 1'b0);
               end
               beats += nb;
            end
            wait_drain(2);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge aclk);
               #1;
               m_tready[2] = ($urandom_range(0, 99) < 30);
            end
            m_tready[2] = 1'b1;
         end
      join
   endtask

   task automatic test_full_rate();
      int t0;
      exp_words(2, 32'h5000, 64);
      t0 = cyc;
      for (int b = 0; b < 16; b++)
         send(2, pack(32'h5000 + 32'(b * 4), 4), 8'h0F, (b == 15), 1'b0);
      total++;
      if (cyc - t0 !== 16) begin
         bad++;
         $display("FAIL full_rate: 16 beats took %0d cycles, want 16", cyc - t0);
      end
      wait_drain(2);
   endtask

   task automatic test_reset_mid();
      m_tready[0] = 1'b0;
      send(0, pack(32'h200, 8), 8'h3F, 1'b0, 1'b0);
      @(negedge aclk);
      total++;
      if (m_vld[0] !== 1'b1 || m_kp[0] !== 8'h0F || m_dat[0] !== pack(32'h200, 4)) begin
         bad++;
         $display("FAIL buffered_before_reset: got v=%b k=%h d=%h, want v=1 k=0f", m_vld[0], m_kp[0], m_dat[0]);
      end
      @(posedge aclk);
      #1;
      aresetn = 1'b0;
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(negedge aclk);
      total++;
      if (m_vld[0] !== 1'b0 || m_kp[0] !== 8'h00) begin
         bad++;
         $display("FAIL after_mid_reset: got v=%b k=%h, want v=0 k=00", m_vld[0], m_kp[0]);
      end
      m_tready[0] = 1'b1;
      repeat (2) @(negedge aclk);
      total++;
      if (m_vld[0] !== 1'b0) begin
         bad++;
         $display("FAIL no_stale_beat: got v=%b, want 0", m_vld[0]);
      end
`ifdef OUT_PACKER_STATS_EN
      total++;
      if (drops[0] !== 32'd0) begin
         bad++;
         $display("FAIL stats_mid_reset: got drops=%0d, want 0", drops[0]);
      end
`endif
      @(posedge aclk);
      #1;
      exp_words(0, 32'h300, 8);
      send(0, pack(32'h300, 8), 8'hFF, 1'b1, 1'b0);
      wait_drain(0);
   endtask

   initial begin
      for (int u = 0; u < 3; u++) begin
         s_tvalid[u] = 1'b0;
         s_tlast[u]  = 1'b0;
         s_tdata[u]  = '0;
         s_tkeep[u]  = '0;
         s_tuser[u]  = '0;
         m_tready[u] = 1'b1;
         frames[u]   = '0;
         drops[u]    = '0;
      end
      test_reset();
      test_s8m4();
      test_s4m8();
      test_partial_keep();
      test_config();
      test_empty_frame();
      test_random_stall();
      test_full_rate();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
